// File: rtl/exc_vector_loader_if.sv
// Exception vector loader bus: exception requests, PC/memory inputs,
// and the EPC/PC write and address-select outputs.
interface exc_vector_loader_if;
  logic        exc_opcode;
  logic        exc_overflow;
  logic        exc_div0;
  logic [31:0] pc_in;
  logic [31:0] mem_data;
  logic [2:0]  iord_sel;
  logic        epc_wr;
  logic [31:0] epc_out;
  logic        pc_wr;
  logic [31:0] pc_out;
  logic        busy;
  logic [1:0]  cause;

  // Control-unit side: raises exceptions, supplies PC and memory read data.
  modport master (
    output exc_opcode, exc_overflow, exc_div0, pc_in, mem_data,
    input  iord_sel, epc_wr, epc_out, pc_wr, pc_out, busy, cause
  );

  // Loader side.
  modport slave (
    input  exc_opcode, exc_overflow, exc_div0, pc_in, mem_data,
    output iord_sel, epc_wr, epc_out, pc_wr, pc_out, busy, cause
  );
endinterface

// File: rtl/exc_vector_loader.sv
// Exception vector loader: on an exception, saves PC-4 to EPC, reads the
// handler vector byte from address 253/254/255 (by cause), waits MEM_WAIT
// cycles for memory, then writes the zero-extended byte into the PC.
module exc_vector_loader #(
  parameter int MEM_WAIT = 2  // memory read latency, 1..7
) (
  input  logic             clk,
  input  logic             reset,
  exc_vector_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SAVE, WAIT, LOAD} state_t;

  localparam logic [2:0] WAIT_LD = 3'(MEM_WAIT);

  state_t      state, nxt;
  logic [1:0]  cause_q, cause_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] vec_q, vec_d;

  // Upper memory bits carry no vector information.
  logic unused_mem;
  assign unused_mem = ^bus.mem_data[31:8];

  // State, cause, wait counter and vector register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cause_q <= 2'd0;
      cnt_q   <= 3'd0;
      vec_q   <= 32'd0;
    end else begin
      state   <= nxt;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
    end
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    nxt          = state;
    cause_d      = cause_q;
    cnt_d        = cnt_q;
    vec_d        = vec_q;
    bus.iord_sel = 3'd0;
    bus.epc_wr   = 1'b0;
    bus.epc_out  = 32'd0;
    bus.pc_wr    = 1'b0;
    bus.pc_out   = 32'd0;
    bus.busy     = 1'b0;
    bus.cause    = cause_q;
    unique case (state)
      IDLE: begin
        // Fixed priority; lower-priority simultaneous requests are dropped.
        if (bus.exc_opcode) begin
          cause_d = 2'd1;
          nxt     = SAVE;
        end else if (bus.exc_overflow) begin
          cause_d = 2'd2;
          nxt     = SAVE;
        end else if (bus.exc_div0) begin
          cause_d = 2'd3;
          nxt     = SAVE;
        end
      end
      SAVE: begin
        bus.busy     = 1'b1;
        bus.iord_sel = {1'b0, cause_q};
        bus.epc_wr   = 1'b1;
        bus.epc_out  = bus.pc_in - 32'd4;  // pc_in already points past the fault
        cnt_d        = WAIT_LD;
        nxt          = WAIT;
      end
      WAIT: begin
        bus.busy     = 1'b1;
        bus.iord_sel = {1'b0, cause_q};
        cnt_d        = cnt_q - 3'd1;
        // Memory data is only trusted on the final wait edge.
        if (cnt_q == 3'd1) begin
          vec_d = {24'b0, bus.mem_data[7:0]};
          nxt   = LOAD;
        end
      end
      LOAD: begin
        bus.busy     = 1'b1;
        bus.iord_sel = {1'b0, cause_q};
        bus.pc_wr    = 1'b1;
        bus.pc_out   = vec_q;
        cause_d      = 2'd0;
        nxt          = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_exc_vector_loader.sv
// Bench for exc_vector_loader: three instances (MEM_WAIT = 2, 1, 7) share
// one stimulus stream and are checked every cycle against a timeline model,
// plus table vectors and hand-written corner sequences.
module tb_exc_vector_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  exc;   // {opcode, overflow, div0}
  logic [31:0] pc, mem;

  exc_vector_loader_if if0 (), if1 (), if2 ();

  assign if0.exc_opcode = exc[2]; assign if0.exc_overflow = exc[1]; assign if0.exc_div0 = exc[0];
  assign if1.exc_opcode = exc[2]; assign if1.exc_overflow = exc[1]; assign if1.exc_div0 = exc[0];
  assign if2.exc_opcode = exc[2]; assign if2.exc_overflow = exc[1]; assign if2.exc_div0 = exc[0];
  assign if0.pc_in = pc; assign if1.pc_in = pc; assign if2.pc_in = pc;
  assign if0.mem_data = mem; assign if1.mem_data = mem; assign if2.mem_data = mem;

  exc_vector_loader #(.MEM_WAIT(2)) u0 (.clk(clk), .reset(rst), .bus(if0.slave));
  exc_vector_loader #(.MEM_WAIT(1)) u1 (.clk(clk), .reset(rst), .bus(if1.slave));
  exc_vector_loader #(.MEM_WAIT(7)) u2 (.clk(clk), .reset(rst), .bus(if2.slave));

  typedef struct packed {
    logic [2:0]  iord;
    logic        epc_wr;
    logic [31:0] epc;
    logic        pc_wr;
    logic [31:0] pc;
    logic        busy;
    logic [1:0]  cause;
  } out_t;

  out_t o [3];
  assign o[0] = {if0.iord_sel, if0.epc_wr, if0.epc_out, if0.pc_wr, if0.pc_out, if0.busy, if0.cause};
  assign o[1] = {if1.iord_sel, if1.epc_wr, if1.epc_out, if1.pc_wr, if1.pc_out, if1.busy, if1.cause};
  assign o[2] = {if2.iord_sel, if2.epc_wr, if2.epc_out, if2.pc_wr, if2.pc_out, if2.busy, if2.cause};

  int mw [3] = '{2, 1, 7};

  // Reference model: t = cycles since the sampling edge (0 = idle).
  int          t  [3];
  logic [1:0]  mc [3];
  logic [31:0] mv [3];

  int total = 0, bad = 0;
  int cyc_n = 0;
  int pw [3], ew [3], last_pw [3];
  bit spacing_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d act=%h exp=%h", nm, cyc_n, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      t[i] = 0; mc[i] = 2'd0; mv[i] = 32'd0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        t[i] = 0; mc[i] = 2'd0; mv[i] = 32'd0;
      end else if (t[i] == 0) begin
        if (exc != 3'b000) begin
          mc[i] = exc[2] ? 2'd1 : exc[1] ? 2'd2 : 2'd3;
          t[i]  = 1;
        end
      end else begin
        if (t[i] == mw[i] + 1) mv[i] = {24'b0, mem[7:0]};
        if (t[i] == mw[i] + 2) begin
          t[i] = 0; mc[i] = 2'd0;
        end else t[i]++;
      end
    end
  endtask

  function automatic out_t model_out(input int i);
    out_t e;
    e.busy   = (t[i] != 0);
    e.iord   = (t[i] != 0) ? {1'b0, mc[i]} : 3'd0;
    e.epc_wr = (t[i] == 1);
    e.epc    = (t[i] == 1) ? pc - 32'd4 : 32'd0;
    e.pc_wr  = (t[i] == mw[i] + 2);
    e.pc     = (t[i] == mw[i] + 2) ? mv[i] : 32'd0;
    e.cause  = mc[i];
    return e;
  endfunction

  task automatic compare_all();
    out_t e;
    cyc_n++;
    for (int i = 0; i < 3; i++) begin
      e = model_out(i);
      chk($sformatf("u%0d.busy", i),     32'(o[i].busy),   32'(e.busy));
      chk($sformatf("u%0d.iord_sel", i), 32'(o[i].iord),   32'(e.iord));
      chk($sformatf("u%0d.epc_wr", i),   32'(o[i].epc_wr), 32'(e.epc_wr));
      chk($sformatf("u%0d.epc_out", i),  o[i].epc,         e.epc);
      chk($sformatf("u%0d.pc_wr", i),    32'(o[i].pc_wr),  32'(e.pc_wr));
      chk($sformatf("u%0d.pc_out", i),   o[i].pc,          e.pc);
      chk($sformatf("u%0d.cause", i),    32'(o[i].cause),  32'(e.cause));
      if (o[i].epc_wr) ew[i]++;
      if (o[i].pc_wr) begin
        pw[i]++;
        if (spacing_on && last_pw[i] >= 0)
          chk($sformatf("u%0d.pc_wr_spacing", i), 32'(cyc_n - last_pw[i]), 32'(mw[i] + 3));
        last_pw[i] = cyc_n;
      end
    end
  endtask

  // Apply inputs just after a falling edge, clock once, check at the next falling edge.
  task automatic cyc(input logic [2:0] e, input logic [31:0] p, input logic [31:0] m);
    exc = e; pc = p; mem = m;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  typedef struct {
    logic [2:0]  exc;
    logic [31:0] pc;
    logic [31:0] mem;
    logic [1:0]  cause;
    logic [31:0] epc;
    logic [31:0] vec;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int p0, p1, p2, e0;
    tbl[0] = '{3'b010, 32'h0000_0104, 32'h0000_005C, 2'd2, 32'h0000_0100, 32'h0000_005C};
    tbl[1] = '{3'b111, 32'h0000_2000, 32'hDEAD_BEAB, 2'd1, 32'h0000_1FFC, 32'h0000_00AB};
    tbl[2] = '{3'b100, 32'h0000_0000, 32'h1234_5677, 2'd1, 32'hFFFF_FFFC, 32'h0000_0077};
    tbl[3] = '{3'b001, 32'h0000_0008, 32'hFFFF_FF01, 2'd3, 32'h0000_0004, 32'h0000_0001};
    tbl[4] = '{3'b011, 32'h0000_0044, 32'h0000_003A, 2'd2, 32'h0000_0040, 32'h0000_003A};
    for (int i = 0; i < 3; i++) begin pw[i] = 0; ew[i] = 0; last_pw[i] = -1; end

    // Reset state
    rst = 1'b1; exc = 3'b000; pc = 32'd0; mem = 32'd0;
    model_reset();
    @(negedge clk);
    compare_all();
    cyc(3'b000, 32'd0, 32'd0);
    rst = 1'b0;
    cyc(3'b000, 32'd0, 32'd0);

    // Table vectors on the MEM_WAIT=2 instance
    foreach (tbl[k]) begin
      p0 = pw[0]; e0 = ew[0];
      cyc(tbl[k].exc, tbl[k].pc, tbl[k].mem);
      chk($sformatf("tbl%0d.cause", k),   32'(o[0].cause),  32'(tbl[k].cause));
      chk($sformatf("tbl%0d.iord", k),    32'(o[0].iord),   32'(tbl[k].cause));
      chk($sformatf("tbl%0d.epc_wr", k),  32'(o[0].epc_wr), 32'd1);
      chk($sformatf("tbl%0d.epc_out", k), o[0].epc,         tbl[k].epc);
      for (int w = 0; w < 2; w++) begin
        cyc(3'b000, tbl[k].pc, tbl[k].mem);
        chk($sformatf("tbl%0d.iord_wait", k), 32'(o[0].iord), 32'(tbl[k].cause));
      end
      cyc(3'b000, tbl[k].pc, tbl[k].mem);
      chk($sformatf("tbl%0d.pc_wr", k),  32'(o[0].pc_wr), 32'd1);
      chk($sformatf("tbl%0d.pc_out", k), o[0].pc,         tbl[k].vec);
      chk($sformatf("tbl%0d.iord_ld", k), 32'(o[0].iord), 32'(tbl[k].cause));
      cyc(3'b000, tbl[k].pc, tbl[k].mem);
      chk($sformatf("tbl%0d.idle", k),   32'(o[0].busy), 32'd0);
      chk($sformatf("tbl%0d.n_epc", k),  32'(ew[0] - e0), 32'd1);
      chk($sformatf("tbl%0d.n_pc", k),   32'(pw[0] - p0), 32'd1);
    end
    for (int w = 0; w < 10; w++) cyc(3'b000, 32'd0, 32'd0);

    // div0 raised while busy with an opcode exception, dropped before idle
    p0 = pw[0];
    cyc(3'b100, 32'h0000_0300, 32'h0000_0011);
    cyc(3'b001, 32'h0000_0300, 32'h0000_0011);
    cyc(3'b001, 32'h0000_0300, 32'h0000_0011);
    cyc(3'b000, 32'h0000_0300, 32'h0000_0011);
    chk("c3.cause_ld", 32'(o[0].cause), 32'd1);
    chk("c3.pc_out",   o[0].pc, 32'h0000_0011);
    for (int w = 0; w < 4; w++) cyc(3'b000, 32'h0000_0300, 32'h0000_0011);
    chk("c3.n_pc",  32'(pw[0] - p0), 32'd1);
    chk("c3.idle",  32'(o[0].busy), 32'd0);
    for (int w = 0; w < 10; w++) cyc(3'b000, 32'd0, 32'd0);

    // Reset asserted mid-WAIT takes effect without a clock edge
    p0 = pw[0]; p1 = pw[1]; p2 = pw[2];
    cyc(3'b010, 32'h0000_0500, 32'h0000_0022);
    cyc(3'b000, 32'h0000_0500, 32'h0000_0022);
    chk("c5.busy_pre", 32'(o[0].busy), 32'd1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("c5.async_u0", 32'(o[0]), 32'd0);
    chk("c5.async_u2_busy", 32'(o[2].busy), 32'd0);
    chk("c5.async_u2_iord", 32'(o[2].iord), 32'd0);
    cyc(3'b000, 32'h0000_0500, 32'h0000_0022);
    cyc(3'b000, 32'h0000_0500, 32'h0000_0022);
    rst = 1'b0;
    for (int w = 0; w < 4; w++) cyc(3'b000, 32'h0000_0500, 32'h0000_0022);
    chk("c5.no_pc_wr_u0", 32'(pw[0] - p0), 32'd0);
    chk("c5.no_pc_wr_u2", 32'(pw[2] - p2), 32'd0);
    cyc(3'b100, 32'h0000_0600, 32'h0000_0033);
    for (int w = 0; w < 10; w++) cyc(3'b000, 32'h0000_0600, 32'h0000_0033);
    chk("c5.resume_u0", 32'(pw[0] - p0), 32'd1);
    chk("c5.resume_u1", 32'(pw[1] - p1), 32'd1);
    chk("c5.resume_u2", 32'(pw[2] - p2), 32'd1);

    // div0 held continuously: back-to-back sequences, mem changing every cycle
    rst = 1'b1;
    cyc(3'b000, 32'd0, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) last_pw[i] = -1;
    spacing_on = 1'b1;
    p1 = pw[1]; p2 = pw[2];
    for (int w = 0; w < 60; w++) cyc(3'b001, $urandom, $urandom);
    spacing_on = 1'b0;
    chk("c6.count_mw1", 32'((pw[1] - p1) >= 12), 32'd1);
    chk("c6.count_mw7", 32'((pw[2] - p2) >= 5), 32'd1);

    // Randomized traffic with occasional asynchronous resets
    for (int w = 0; w < 400; w++) begin
      rst = ($urandom_range(0, 49) == 0);
      cyc(($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000, $urandom, $urandom);
    end
    rst = 1'b0;
    for (int w = 0; w < 12; w++) cyc(3'b000, $urandom, $urandom);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
